fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write scheduler sharing one async_fifo write port between NUM_REQ requesters.
//  - Grants one requester at a time, for up to MAX_BURST words.
//  - Per word: presents DATA_IN, then generates a clean W_EN strobe (the FIFO writes on the W_EN rising edge).
//  - Stalls on a synchronized FULL. Sits between the producer blocks and the FIFO write side.
// PARAMETERS
//  DATA_WIDTH   8  width of each word, matches the FIFO
//  NUM_REQ      4  number of requesters, >=2
//  MAX_BURST    4  max words per grant before rotating, >=1
//  SYNC_STAGES  2  flops in the FULL synchronizer, >=2
// PORTS
//  CLK       in   1               single clock; all logic on posedge
//  RST       in   1               synchronous, active-high reset
//  REQ       in   NUM_REQ         requester i has a word valid on REQ_DATA slice i
//  REQ_DATA  in   NUM_REQ*DW      word i at [i*DW +: DW]; held stable while REQ[i]=1
//  ACK       out  NUM_REQ         one-hot, 1-cycle pulse: word of requester i was written
//  FULL      in   1               FIFO FULL, async to CLK; synchronized internally
//  DATA_IN   out  DATA_WIDTH      FIFO write data
//  W_EN      out  1               FIFO write strobe, registered, glitch-free
//  GRANT     out  $clog2(NUM_REQ) index of the current/last granted requester
//  BUSY      out  1               FSM not in IDLE
// BEHAVIOUR
//  Reset (RST=1 at posedge): state=IDLE, W_EN=0, ACK=0, DATA_IN=0, GRANT=0, BUSY=0,
//   rr_ptr=0, burst_cnt=0, FULL sync flops=1 (pessimistic full).
//  FSM states: IDLE, SETUP, STROBE, SETTLE.
//  - IDLE: if REQ!=0 and full_s=0, pick the first set REQ bit searching upward from rr_ptr, with wrap.
//    Latch GRANT, set burst_cnt=0, go to SETUP.
//  - SETUP: DATA_IN<=REQ_DATA[GRANT], W_EN=0. Next state is STROBE, giving 1 cycle of setup before the edge.
//  - STROBE: W_EN=1 for exactly 1 cycle. ACK[GRANT]=1 in this same cycle, and burst_cnt++.
//  - SETTLE: W_EN=0 for SYNC_STAGES+1 cycles (counter), so that FULL from this write is visible on full_s.
//    At the end of the count:
//    - If full_s=1: stay in SETTLE (stall) until full_s=0. This also covers a grant pending when the FIFO fills.
//    - Else if REQ[GRANT]=1 and burst_cnt<MAX_BURST: go to SETUP with the same GRANT.
//    - Else: rr_ptr<=GRANT+1 (mod NUM_REQ), then go to IDLE.
//  Throughput: 1 word per SYNC_STAGES+3 cycles. The W_EN high pulse is 1 cycle, and the low time is >= SYNC_STAGES+2 cycles.
//  Boundary cases:
//  - FULL asserted while in IDLE: no grant and no W_EN.
//  - FULL asserted during SETUP or STROBE: the strobe still completes. The FIFO drops the word if full; this is
//    ACKed anyway, because the SETTLE wait guarantees it occurs only on an async race. Documented as a FIFO-side limitation.
//  - Requester drops REQ after ACK: its burst ends at SETTLE exit.
//  - All REQ low in IDLE: hold, BUSY=0.
//  - Single active requester: it is re-granted after rotation without losing cycles beyond IDLE (1 cycle).
//  - rr_ptr wraps NUM_REQ-1 -> 0.
//  - Reset mid-burst: takes effect at the next posedge. W_EN drops to 0 the same cycle, and no ACK is issued.
//  Width rules: burst_cnt is $clog2(MAX_BURST+1) bits, and the SETTLE counter is $clog2(SYNC_STAGES+2) bits.
//   GRANT arithmetic is modulo NUM_REQ, with explicit wrap (no reliance on power-of-2).
// STRUCTURE
//  Package fifo_arb_pkg holds:
//  - typedef enum logic [1:0] {IDLE, SETUP, STROBE, SETTLE} arb_state_t;
//  - function rr_pick(req, ptr) returning index plus found flag.
//  Sub-module sync_2ff #(STAGES): FULL synchronizer with a reset value parameter (1 here).
//  Everything else lives in fifo_wr_arbiter: FSM, counters, data mux, ACK decode.
// TESTING
//  1 Reset: RST=1 for 3 cycles with REQ=4'b1111.
//    -> W_EN=0, ACK=0, BUSY=0 throughout. The first W_EN is no earlier than SYNC_STAGES+1 cycles after RST falls.
//  2 Single requester: REQ=4'b0100, data 8'hA5, FULL=0.
//    -> GRANT=2, and DATA_IN=8'hA5 one cycle before W_EN rises.
//    -> ACK=4'b0100 coincident with W_EN. The next strobe is exactly SYNC_STAGES+3 cycles later.
//  3 Round-robin: REQ=4'b1111, MAX_BURST=4, FULL=0.
//    -> 4 ACKs to requester 0, then 4 to 1, 4 to 2, 4 to 3, then back to 0. Grant order is 0,1,2,3,0.
//  4 Full stall: assert FULL after the 3rd write of a burst.
//    -> No W_EN while full_s=1, and BUSY=1.
//    -> Release FULL: writes resume with the same GRANT, and the remaining burst words are not lost.
//  5 Mid-burst release: REQ[1] drops after its 2nd ACK while REQ[3]=1.
//    -> GRANT moves to 3 via IDLE, and requester 1 gets exactly 2 ACKs.
//  6 Reset mid-burst: pulse RST in the STROBE cycle.
//    -> The next cycle has W_EN=0, ACK=0, and state IDLE. rr_ptr=0 after release, so grant 0 wins with REQ=4'b1111.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Round-robin pick returns the winning index together with a found flag.
package fifo_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, SETTLE} arb_state_t;

    localparam int PICK_W = 5;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } rr_pick_t;

    // First set bit searching upward from ptr, wrapping modulo n (n <= 32).
    function automatic rr_pick_t rr_pick(input logic [31:0] req,
                                         input int ptr,
                                         input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (!r.found && req[j]) begin
                    r.found = 1'b1;
                    r.idx   = PICK_W'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO write-side bundle of the write arbiter.
// master = arbiter side, slave = producers plus FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            ACK;
    logic                          FULL;
    logic [DATA_WIDTH-1:0]         DATA_IN;
    logic                          W_EN;
    logic [GW-1:0]                 GRANT;
    logic                          BUSY;

    modport master (
        input  REQ, REQ_DATA, FULL,
        output ACK, DATA_IN, W_EN, GRANT, BUSY
    );

    modport slave (
        output REQ, REQ_DATA, FULL,
        input  ACK, DATA_IN, W_EN, GRANT, BUSY
    );

endinterface

// File: rtl/fifo_wr_arbiter_sync_2ff.sv
// Multi-flop synchronizer with a selectable reset value.
// Used to bring the asynchronous FIFO FULL flag into the arbiter clock domain.
module sync_2ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one async FIFO write port.
// Each word: data setup cycle, one-cycle W_EN strobe, then a settle wait for FULL.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_wr_arbiter_if.master bus
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(SYNC_STAGES + 2);

    arb_state_t              r_state;
    arb_state_t              w_nxt_state;
    logic [GW-1:0]           r_grant;
    logic [GW-1:0]           r_rr_ptr;
    logic [GW-1:0]           w_sel;
    logic [GW-1:0]           w_ptr_inc;
    logic [BW-1:0]           r_burst_cnt;
    logic [SW-1:0]           r_settle_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_wen;
    logic [NUM_REQ-1:0]      r_ack;
    logic [NUM_REQ-1:0]      w_onehot;
    logic                    w_full_s;
    logic                    w_settle_done;
    logic                    w_more;
    rr_pick_t                w_pick;

    sync_2ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_full_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (bus.FULL),
        .o_q   (w_full_s)
    );

    assign w_pick        = rr_pick(32'(bus.REQ), int'(r_rr_ptr), NUM_REQ);
    assign w_sel         = (r_state == IDLE) ? GW'(w_pick.idx) : r_grant;
    assign w_settle_done = (r_settle_cnt == SW'(SYNC_STAGES));
    assign w_more        = bus.REQ[r_grant] && (r_burst_cnt < BW'(MAX_BURST));
    assign w_onehot      = NUM_REQ'(1) << r_grant;
    assign w_ptr_inc     = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);

    always_comb begin
        w_nxt_state = r_state;
        unique case (r_state)
            IDLE:   if (w_pick.found && !w_full_s) w_nxt_state = SETUP;
            SETUP:  w_nxt_state = STROBE;
            STROBE: w_nxt_state = SETTLE;
            SETTLE: begin
                // Stall here while full; the pending grant survives the stall.
                if (w_settle_done && !w_full_s) begin
                    w_nxt_state = w_more ? SETUP : IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_settle_cnt <= '0;
            r_data       <= '0;
            r_wen        <= 1'b0;
            r_ack        <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_wen   <= (w_nxt_state == STROBE);
            r_ack   <= (w_nxt_state == STROBE) ? w_onehot : '0;
            if (w_nxt_state == SETUP) begin
                r_data <= bus.REQ_DATA[w_sel*DATA_WIDTH +: DATA_WIDTH];
            end
            unique case (r_state)
                IDLE: begin
                    if (w_nxt_state == SETUP) begin
                        r_grant     <= w_sel;
                        r_burst_cnt <= '0;
                    end
                end
                STROBE: begin
                    r_burst_cnt  <= r_burst_cnt + BW'(1);
                    r_settle_cnt <= '0;
                end
                SETTLE: begin
                    if (!w_settle_done) r_settle_cnt <= r_settle_cnt + SW'(1);
                    if (w_nxt_state == IDLE) r_rr_ptr <= w_ptr_inc;
                end
                default: ;
            endcase
        end
    end

    assign bus.ACK     = r_ack;
    assign bus.DATA_IN = r_data;
    assign bus.W_EN    = r_wen;
    assign bus.GRANT   = r_grant;
    assign bus.BUSY    = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corners,
// and randomized traffic against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .MAX_BURST   (MB),
        .SYNC_STAGES (SS)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [NR-1:0] req;
        int            exp_g;
    } vec_t;

    typedef struct {
        int       idx;
        logic [7:0] d;
    } wr_t;

    vec_t       tv[6];
    wr_t        exp_q[$];
    logic [7:0] wq[NR][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.REQ = '0;
        bus.REQ_DATA = '0;
        bus.FULL = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_wen(input int max, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (bus.W_EN) ok = 1'b1;
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic drive_from_queues();
        for (int i = 0; i < NR; i++) begin
            if (wq[i].size() > 0) begin
                bus.REQ[i] = 1'b1;
                bus.REQ_DATA[i*DW +: DW] = wq[i][0];
            end else begin
                bus.REQ[i] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] prev_d;
        logic [7:0] w4[5];
        int         cnt, k, a1, n, j, mp, last_w, cyc, tot;
        bit         seen3, dropped, saw_idle, busy_ok, found;
        int         rem[NR];
        int         pos[NR];
        wr_t        e;

        tv[0] = '{4'b0001, 0};
        tv[1] = '{4'b0100, 2};
        tv[2] = '{4'b1100, 2};
        tv[3] = '{4'b1000, 3};
        tv[4] = '{4'b1010, 1};
        tv[5] = '{4'b1111, 0};

        // Reset held 3 cycles with all requesters active
        bus.REQ = 4'b1111;
        bus.REQ_DATA = 32'h44332211;
        bus.FULL = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", {bus.W_EN, bus.ACK, bus.BUSY}, 0);
        end
        chk("reset_grant", bus.GRANT, 0);
        chk("reset_data", bus.DATA_IN, 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && !bus.W_EN; i++) begin
            @(negedge clk);
            cnt++;
        end
        chk("reset_first_wen_late", (cnt >= SS + 1) ? 1 : 0, 1);
        chk("reset_first_wen_seen", bus.W_EN, 1);

        // Vector table: first grant after reset
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < NR; i++) bus.REQ_DATA[i*DW +: DW] = 8'(8'h30 + i);
            bus.REQ = tv[v].req;
            wait_wen(20, "vec");
            chk("vec_grant", bus.GRANT, tv[v].exp_g);
            chk("vec_ack", bus.ACK, 32'(1 << tv[v].exp_g));
            chk("vec_data", bus.DATA_IN, 32'(8'h30 + tv[v].exp_g));
        end

        // Single requester timing
        do_reset();
        bus.REQ_DATA[2*DW +: DW] = 8'hA5;
        bus.REQ = 4'b0100;
        prev_d = 8'h00;
        for (int i = 0; i < 20 && !bus.W_EN; i++) begin
            prev_d = bus.DATA_IN;
            @(negedge clk);
        end
        chk("single_grant", bus.GRANT, 2);
        chk("single_setup_data", prev_d, 8'hA5);
        chk("single_ack", bus.ACK, 4'b0100);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.W_EN) break;
        end
        chk("single_period", cnt, SS + 3);

        // Round-robin over all four
        do_reset();
        bus.REQ = 4'b1111;
        n = 0;
        for (int i = 0; i < 300 && n < 17; i++) begin
            @(negedge clk);
            if (bus.W_EN) begin
                chk("rr_ack", bus.ACK, 32'(1 << ((n / MB) % NR)));
                n++;
            end
        end
        chk("rr_count", n, 17);

        // Full stall after the 3rd write of a burst
        do_reset();
        w4 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        k = 0;
        bus.REQ_DATA[DW-1:0] = w4[0];
        bus.REQ = 4'b0001;
        for (int i = 0; i < 100 && k < 3; i++) begin
            @(negedge clk);
            if (bus.W_EN) begin
                chk("stall_pre_data", bus.DATA_IN, w4[k]);
                k++;
                bus.REQ_DATA[DW-1:0] = w4[k];
            end
        end
        bus.FULL = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_hold", {bus.W_EN, bus.BUSY}, 2'b01);
        end
        bus.FULL = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 20 && !bus.W_EN; i++) begin
            @(negedge clk);
            if (!bus.BUSY) busy_ok = 1'b0;
        end
        chk("stall_resume_wen", bus.W_EN, 1);
        chk("stall_resume_data", bus.DATA_IN, 8'hC4);
        chk("stall_resume_grant", bus.GRANT, 0);
        chk("stall_no_idle", busy_ok, 1);

        // Mid-burst release of requester 1
        do_reset();
        bus.REQ_DATA[1*DW +: DW] = 8'h51;
        bus.REQ_DATA[3*DW +: DW] = 8'h53;
        bus.REQ = 4'b1010;
        a1 = 0; seen3 = 0; dropped = 0; saw_idle = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (dropped && !bus.BUSY) saw_idle = 1'b1;
            if (bus.W_EN && bus.ACK[1]) begin
                a1++;
                if (a1 == 2) begin
                    bus.REQ[1] = 1'b0;
                    dropped = 1'b1;
                end
            end
            if (bus.W_EN && bus.ACK[3] && !seen3) begin
                seen3 = 1'b1;
                chk("release_grant3", bus.GRANT, 3);
                chk("release_via_idle", saw_idle, 1);
            end
        end
        chk("release_acks1", a1, 2);
        chk("release_seen3", seen3, 1);

        // Reset in a STROBE cycle of requester 2
        do_reset();
        bus.REQ = 4'b1111;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.W_EN && bus.GRANT == 2) found = 1'b1;
        end
        chk("rstmid_reached", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_outs", {bus.W_EN, bus.ACK, bus.BUSY}, 0);
        rst = 1'b0;
        wait_wen(20, "rstmid");
        chk("rstmid_grant", bus.GRANT, 0);
        chk("rstmid_ack", bus.ACK, 4'b0001);

        // Randomized traffic with random FULL against a round-robin model
        do_reset();
        mp = 0;
        for (int r = 0; r < 5; r++) begin
            exp_q.delete();
            tot = 0;
            for (int i = 0; i < NR; i++) begin
                wq[i].delete();
                cnt = $urandom_range(0, 7);
                for (int t = 0; t < cnt; t++) wq[i].push_back(8'($urandom));
                rem[i] = cnt;
                pos[i] = 0;
                tot += cnt;
            end
            while (tot > 0) begin
                j = mp;
                for (int t = 0; t < NR; t++) begin
                    if (rem[(mp + t) % NR] > 0) begin
                        j = (mp + t) % NR;
                        break;
                    end
                end
                n = (rem[j] < MB) ? rem[j] : MB;
                for (int t = 0; t < n; t++) begin
                    e.idx = j;
                    e.d = wq[j][pos[j]];
                    exp_q.push_back(e);
                    pos[j]++;
                end
                rem[j] -= n;
                tot -= n;
                mp = (j + 1) % NR;
            end
            drive_from_queues();
            last_w = -1000;
            found = 0;
            for (cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk);
                if (bus.W_EN) begin
                    chk("rnd_gap", (cyc - last_w >= SS + 3) ? 1 : 0, 1);
                    last_w = cyc;
                    if (exp_q.size() == 0) begin
                        chk("rnd_extra_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rnd_data", bus.DATA_IN, e.d);
                        chk("rnd_ack", bus.ACK, 32'(1 << e.idx));
                        chk("rnd_grant", bus.GRANT, e.idx);
                        void'(wq[e.idx].pop_front());
                    end
                end else if (bus.ACK != 0) begin
                    chk("rnd_ack_idle", bus.ACK, 0);
                end
                if (exp_q.size() == 0 && !bus.BUSY) begin
                    found = 1'b1;
                    break;
                end
                if ($urandom_range(0, 19) == 0) bus.FULL = ~bus.FULL;
                drive_from_queues();
            end
            chk("rnd_round_done", found, 1);
            bus.FULL = 1'b0;
            bus.REQ = '0;
            repeat (SS + 2) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
